// File: rtl/multicycle_datapath_if.sv
// Memory bus between the multicycle datapath and its unified instruction/data
// memory. A single outstanding access at a time; an access completes on any
// rising cpu_clk edge where mem_req and mem_ready are both high.
//
// Signals
//   mem_req   : access request, held until accepted
//   mem_we    : 1 = write, 0 = read (only meaningful while mem_req=1)
//   mem_addr  : byte address (only meaningful while mem_req=1)
//   mem_wdata : store data (only meaningful while mem_req=1 and mem_we=1)
//   mem_rdata : read data, sampled on the accepting edge
//   mem_ready : memory ready; completes the pending access
//
// Modports
//   master : the datapath side (drives request, address, write data)
//   slave  : the memory side (drives read data and ready)
interface multicycle_datapath_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath with a single shared memory port.
// Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB]; memory
// stages hold their request until the memory accepts it.
//
// Parameters
//   RESET_PC : PC value loaded on reset
//   OVF_TRAP : 1 = signed overflow on add/sub/addi suppresses the write-back
//
// Ports
//   cpu_clk    : sole clock, rising edge
//   reset      : asynchronous, active-high
//   bus        : memory bus (master side)
//   reg_num    : register-file test read address
//   reg_data   : register[reg_num], combinational
//   PC_Current : program counter
//   inst       : instruction register
//   state      : FSM state code
//   overflow   : pulse in EXEC on signed overflow of add/sub/addi
//   illegal    : pulse in EXEC on an unsupported opcode/funct
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | read mem[PC]; on accept IR <= rdata, PC <= PC+4
// DECODE | A <= reg[rs], B <= reg[rt]
// EXEC   | ALU op / address calc / branch / jump resolution
// MEM    | load or store at ALUOut; on accept load fills MDR
// WB     | write ALUOut or MDR to rd (R-type) or rt
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          OVF_TRAP = 1'b1
) (
    input  logic                         cpu_clk,
    input  logic                         reset,
    multicycle_datapath_if.master        bus,
    input  logic [4:0]                   reg_num,
    output logic [31:0]                  reg_data,
    output logic [31:0]                  PC_Current,
    output logic [31:0]                  inst,
    output logic [2:0]                   state,
    output logic                         overflow,
    output logic                         illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    state_t      state_q, state_d;
    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [31:0] regs [32];
    logic        ovf_q;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] sign_imm, zero_imm;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign imm16    = ir[15:0];
    assign imm26    = ir[25:0];
    assign sign_imm = {{16{imm16[15]}}, imm16};
    assign zero_imm = {16'h0000, imm16};

    logic [31:0] add_res, sub_res, addi_res;
    logic        add_ovf, sub_ovf, addi_ovf;

    assign add_res  = a + b;
    assign sub_res  = a - b;
    assign addi_res = a + sign_imm;
    // Signed overflow: operands (after negating b for sub) share a sign that the result lost.
    assign add_ovf  = (a[31] == b[31])        && (add_res[31]  != a[31]);
    assign sub_ovf  = (a[31] != b[31])        && (sub_res[31]  != a[31]);
    assign addi_ovf = (a[31] == sign_imm[31]) && (addi_res[31] != a[31]);

    logic        is_alu, is_ldst, is_beq, is_bne, is_j, is_jal, is_jr, bad_op;
    logic        is_lw, is_sw;
    logic [31:0] alu_result;
    logic        alu_ovf;

    assign is_lw = (opcode == OP_LW);
    assign is_sw = (opcode == OP_SW);

    always_comb begin
        is_alu     = 1'b0;
        is_ldst    = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_jal     = 1'b0;
        is_jr      = 1'b0;
        bad_op     = 1'b0;
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD: begin is_alu = 1'b1; alu_result = add_res; alu_ovf = add_ovf; end
                    F_SUB: begin is_alu = 1'b1; alu_result = sub_res; alu_ovf = sub_ovf; end
                    F_AND: begin is_alu = 1'b1; alu_result = a & b; end
                    F_OR:  begin is_alu = 1'b1; alu_result = a | b; end
                    F_SLT: begin is_alu = 1'b1; alu_result = {31'd0, $signed(a) < $signed(b)}; end
                    F_SLL: begin is_alu = 1'b1; alu_result = b << shamt; end
                    F_SRL: begin is_alu = 1'b1; alu_result = b >> shamt; end
                    F_JR:  is_jr = 1'b1;
                    default: bad_op = 1'b1;
                endcase
            end
            OP_ADDI: begin is_alu = 1'b1; alu_result = addi_res; alu_ovf = addi_ovf; end
            OP_ANDI: begin is_alu = 1'b1; alu_result = a & zero_imm; end
            OP_ORI:  begin is_alu = 1'b1; alu_result = a | zero_imm; end
            OP_LW, OP_SW: is_ldst = 1'b1;
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_J:    is_j   = 1'b1;
            OP_JAL:  is_jal = 1'b1;
            default: bad_op = 1'b1;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = pc;
        bus.mem_wdata = b;
        case (state_q)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_alu)       state_d = S_WB;
                else if (is_ldst) state_d = S_MEM;
                else              state_d = S_FETCH;
            end
            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = is_sw;
                bus.mem_addr = alu_out;
                if (bus.mem_ready) state_d = is_sw ? S_FETCH : S_WB;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
        // The state register already reads FETCH during reset; the request
        // must still stay low until reset is released.
        if (reset) begin
            bus.mem_req = 1'b0;
            bus.mem_we  = 1'b0;
        end
    end

    // ---------------- Datapath registers ----------------
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        wb_en;

    assign wb_dst  = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_data = is_lw ? mdr : alu_out;
    assign wb_en   = (wb_dst != 5'd0) && !(OVF_TRAP && ovf_q);

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir <= bus.mem_rdata;
                        pc <= pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    a <= regs[rs];
                    b <= regs[rt];
                end
                S_EXEC: begin
                    ovf_q <= 1'b0;
                    if (is_alu) begin
                        alu_out <= alu_result;
                        ovf_q   <= alu_ovf;
                    end
                    if (is_ldst) alu_out <= addi_res;
                    // pc already holds the address of the next instruction here.
                    if ((is_beq && (a == b)) || (is_bne && (a != b)))
                        pc <= pc + {sign_imm[29:0], 2'b00};
                    if (is_j || is_jal) pc <= {pc[31:28], imm26, 2'b00};
                    if (is_jal) regs[31] <= pc;
                    if (is_jr) pc <= a;
                end
                S_MEM: begin
                    if (bus.mem_ready && is_lw) mdr <= bus.mem_rdata;
                end
                S_WB: begin
                    if (wb_en) regs[wb_dst] <= wb_data;
                end
                default: ;
            endcase
        end
    end

    assign reg_data   = (reg_num == 5'd0) ? 32'd0 : regs[reg_num];
    assign PC_Current = pc;
    assign inst       = ir;
    assign state      = state_q;
    assign overflow   = (state_q == S_EXEC) && alu_ovf;
    assign illegal    = (state_q == S_EXEC) && bad_op;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed self-checking bench for multicycle_datapath. Two instances run the
// same program side by side: dut0 traps overflow, dut1 writes the wrapped sum.
module tb_multicycle_datapath;

    logic        cpu_clk;
    logic        reset;
    logic        ready;
    logic [4:0]  reg_num0, reg_num1;
    logic [31:0] reg_data0, reg_data1;
    logic [31:0] pc0, pc1, inst0, inst1;
    logic [2:0]  state0, state1;
    logic        ovf0, ovf1, ill0, ill1;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [0:511];
    logic [31:0] dmem [0:511];
    bit          dvalid [0:511];

    multicycle_datapath_if bus0();
    multicycle_datapath_if bus1();

    multicycle_datapath dut0 (
        .cpu_clk(cpu_clk), .reset(reset), .bus(bus0),
        .reg_num(reg_num0), .reg_data(reg_data0), .PC_Current(pc0), .inst(inst0),
        .state(state0), .overflow(ovf0), .illegal(ill0)
    );

    multicycle_datapath #(.RESET_PC(32'h0000_0000), .OVF_TRAP(1'b0)) dut1 (
        .cpu_clk(cpu_clk), .reset(reset), .bus(bus1),
        .reg_num(reg_num1), .reg_data(reg_data1), .PC_Current(pc1), .inst(inst1),
        .state(state1), .overflow(ovf1), .illegal(ill1)
    );

    assign bus0.mem_ready = ready;
    assign bus1.mem_ready = ready;
    assign bus0.mem_rdata = dvalid[bus0.mem_addr[10:2]] ? dmem[bus0.mem_addr[10:2]] : imem[bus0.mem_addr[10:2]];
    assign bus1.mem_rdata = dvalid[bus1.mem_addr[10:2]] ? dmem[bus1.mem_addr[10:2]] : imem[bus1.mem_addr[10:2]];

    always @(posedge cpu_clk) begin
        if (bus0.mem_req && bus0.mem_we && bus0.mem_ready) begin
            dmem[bus0.mem_addr[10:2]]   <= bus0.mem_wdata;
            dvalid[bus0.mem_addr[10:2]] <= 1'b1;
        end
    end

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_op(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge cpu_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_reg0(input string tag, input logic [4:0] n, input logic [31:0] expected);
        reg_num0 = n;
        #1;
        check(tag, reg_data0, expected);
    endtask

    task automatic check_reg1(input string tag, input logic [4:0] n, input logic [31:0] expected);
        reg_num1 = n;
        #1;
        check(tag, reg_data1, expected);
    endtask

    // Simple ALU instructions from 0x58 on: destination register and value.
    logic [4:0]  alu_rd  [7];
    logic [31:0] alu_exp [7];

    initial begin
        reset    = 1'b1;
        ready    = 1'b1;
        reg_num0 = 5'd0;
        reg_num1 = 5'd0;
        for (int i = 0; i < 512; i++) imem[i] = 32'h0;

        imem[32'h00 >> 2] = i_op(6'b001000, 5'd0, 5'd1, 16'd5);          // addi $1,$0,5
        imem[32'h04 >> 2] = i_op(6'b001000, 5'd0, 5'd2, 16'd7);          // addi $2,$0,7
        imem[32'h08 >> 2] = r_op(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000);     // add $3,$1,$2
        imem[32'h0C >> 2] = i_op(6'b101011, 5'd0, 5'd3, 16'd4);          // sw $3,4($0)
        imem[32'h10 >> 2] = i_op(6'b100011, 5'd0, 5'd4, 16'd4);          // lw $4,4($0)
        imem[32'h14 >> 2] = j_op(6'b000010, 32'h20);                      // j 0x20
        imem[32'h20 >> 2] = i_op(6'b000100, 5'd1, 5'd1, 16'd2);          // beq $1,$1,+2
        imem[32'h2C >> 2] = i_op(6'b000101, 5'd1, 5'd1, 16'd2);          // bne $1,$1,+2
        imem[32'h30 >> 2] = i_op(6'b000101, 5'd1, 5'd2, 16'd3);          // bne $1,$2,+3
        imem[32'h40 >> 2] = j_op(6'b000011, 32'h100);                     // jal 0x100
        imem[32'h100 >> 2] = r_op(5'd31, 5'd0, 5'd0, 5'd0, 6'b001000);   // jr $31
        imem[32'h44 >> 2] = i_op(6'b001000, 5'd0, 5'd5, 16'h7FFF);       // addi $5,$0,0x7FFF
        imem[32'h48 >> 2] = i_op(6'b001000, 5'd0, 5'd10, 16'hFFFF);      // addi $10,$0,-1
        imem[32'h4C >> 2] = r_op(5'd0, 5'd10, 5'd6, 5'd1, 6'b000010);    // srl $6,$10,1
        imem[32'h50 >> 2] = i_op(6'b001000, 5'd0, 5'd7, 16'd1);          // addi $7,$0,1
        imem[32'h54 >> 2] = r_op(5'd6, 5'd7, 5'd8, 5'd0, 6'b100000);     // add $8,$6,$7
        imem[32'h58 >> 2] = r_op(5'd10, 5'd7, 5'd9, 5'd0, 6'b101010);    // slt $9,$10,$7
        imem[32'h5C >> 2] = r_op(5'd0, 5'd7, 5'd11, 5'd4, 6'b000000);    // sll $11,$7,4
        imem[32'h60 >> 2] = i_op(6'b001100, 5'd10, 5'd12, 16'hF0F0);     // andi $12,$10,0xF0F0
        imem[32'h64 >> 2] = r_op(5'd1, 5'd2, 5'd13, 5'd0, 6'b100010);    // sub $13,$1,$2
        imem[32'h68 >> 2] = r_op(5'd1, 5'd2, 5'd14, 5'd0, 6'b100101);    // or $14,$1,$2
        imem[32'h6C >> 2] = r_op(5'd1, 5'd2, 5'd15, 5'd0, 6'b100100);    // and $15,$1,$2
        imem[32'h70 >> 2] = i_op(6'b001101, 5'd1, 5'd17, 16'h8000);      // ori $17,$1,0x8000
        imem[32'h74 >> 2] = i_op(6'b001000, 5'd0, 5'd0, 16'd9);          // addi $0,$0,9
        imem[32'h78 >> 2] = 32'hFC00_0000;                                // opcode 111111
        imem[32'h7C >> 2] = r_op(5'd1, 5'd2, 5'd3, 5'd0, 6'b111111);     // bad funct
        imem[32'h80 >> 2] = i_op(6'b100011, 5'd0, 5'd16, 16'd4);         // lw $16,4($0)

        alu_rd[0] = 5'd9;  alu_exp[0] = 32'h0000_0001;
        alu_rd[1] = 5'd11; alu_exp[1] = 32'h0000_0010;
        alu_rd[2] = 5'd12; alu_exp[2] = 32'h0000_F0F0;
        alu_rd[3] = 5'd13; alu_exp[3] = 32'hFFFF_FFFE;
        alu_rd[4] = 5'd14; alu_exp[4] = 32'h0000_0007;
        alu_rd[5] = 5'd15; alu_exp[5] = 32'h0000_0005;
        alu_rd[6] = 5'd17; alu_exp[6] = 32'h0000_8005;

        // Reset state
        tick(2);
        check("rst_state", {29'd0, state0}, 32'd0);
        check("rst_pc", pc0, 32'h0);
        check("rst_ir", inst0, 32'h0);
        check("rst_req", {31'd0, bus0.mem_req}, 32'd0);
        check("rst_flags", {30'd0, ovf0, ill0}, 32'd0);
        check_reg0("rst_reg1", 5'd1, 32'h0);

        reset = 1'b0;
        #1;
        check("fetch_req", {31'd0, bus0.mem_req}, 32'd1);
        check("fetch_addr0", bus0.mem_addr, 32'h0);

        // addi/addi/add in 12 cycles
        tick(12);
        check_reg0("add_r3", 5'd3, 32'd12);
        check_reg0("addi_r1", 5'd1, 32'd5);
        check("add_pc", pc0, 32'h0000_000C);
        check("add_state", {29'd0, state0}, 32'd0);

        // sw $3,4($0) with 3-cycle stall in FETCH and MEM
        ready = 1'b0;
        tick(3);
        check("sw_fstall_state", {29'd0, state0}, 32'd0);
        check("sw_fstall_addr", bus0.mem_addr, 32'h0000_000C);
        check("sw_fstall_ir", inst0, imem[32'h08 >> 2]);
        ready = 1'b1;
        tick(1);
        check("decode_req", {31'd0, bus0.mem_req}, 32'd0);
        tick(2);
        check("sw_mem_state", {29'd0, state0}, 32'd3);
        ready = 1'b0;
        tick(3);
        check("sw_mstall_state", {29'd0, state0}, 32'd3);
        check("sw_ctrl", {30'd0, bus0.mem_req, bus0.mem_we}, 32'd3);
        check("sw_addr", bus0.mem_addr, 32'h4);
        check("sw_wdata", bus0.mem_wdata, 32'd12);
        ready = 1'b1;
        tick(1);
        check("sw_done_state", {29'd0, state0}, 32'd0);
        check("sw_done_pc", pc0, 32'h10);
        check("sw_mem", dmem[1], 32'd12);

        // lw $4,4($0) with the same stalls: 11 cycles
        ready = 1'b0;
        tick(3);
        ready = 1'b1;
        tick(3);
        check("lw_mem_ctrl", {30'd0, bus0.mem_req, bus0.mem_we}, 32'd2);
        check("lw_mem_addr", bus0.mem_addr, 32'h4);
        ready = 1'b0;
        tick(3);
        check("lw_mstall_state", {29'd0, state0}, 32'd3);
        ready = 1'b1;
        tick(1);
        check("lw_wb_state", {29'd0, state0}, 32'd4);
        tick(1);
        check_reg0("lw_r4", 5'd4, 32'd12);
        check("lw_done_state", {29'd0, state0}, 32'd0);

        // j 0x20, beq taken, bne not taken, bne taken
        tick(3);
        check("j_pc", pc0, 32'h20);
        tick(3);
        check("beq_pc", pc0, 32'h2C);
        check("beq_fetch", bus0.mem_addr, 32'h2C);
        tick(3);
        check("bne_nt_pc", pc0, 32'h30);
        tick(3);
        check("bne_t_pc", pc0, 32'h40);

        // jal 0x100 then jr $31
        tick(3);
        check("jal_pc", pc0, 32'h100);
        check_reg0("jal_r31", 5'd31, 32'h44);
        tick(3);
        check("jr_pc", pc0, 32'h44);
        check("jr_fetch", bus0.mem_addr, 32'h44);

        // Build 0x7FFFFFFF and 1, then overflowing add
        tick(16);
        check_reg0("addi_r5", 5'd5, 32'h0000_7FFF);
        check_reg0("srl_r6", 5'd6, 32'h7FFF_FFFF);
        check("pre_ovf_pc", pc0, 32'h54);
        tick(2);
        check("ovf_pulse0", {31'd0, ovf0}, 32'd1);
        check("ovf_pulse1", {31'd0, ovf1}, 32'd1);
        tick(1);
        check("ovf_end", {31'd0, ovf0}, 32'd0);
        tick(1);
        check_reg0("ovf_trap_r8", 5'd8, 32'h0);
        check_reg1("ovf_wrap_r8", 5'd8, 32'h8000_0000);

        // slt/sll/andi/sub/or/and/ori, 4 cycles each
        for (int i = 0; i < 7; i++) begin
            tick(4);
            check_reg0($sformatf("alu_r%0d", alu_rd[i]), alu_rd[i], alu_exp[i]);
        end

        // write to $0 discarded
        tick(4);
        check_reg0("r0_zero", 5'd0, 32'h0);
        check("r0_pc", pc0, 32'h78);

        // illegal opcode and illegal funct
        tick(2);
        check("ill_op_pulse", {31'd0, ill0}, 32'd1);
        tick(1);
        check("ill_op_end", {31'd0, ill0}, 32'd0);
        check("ill_op_pc", pc0, 32'h7C);
        tick(2);
        check("ill_fn_pulse", {31'd0, ill0}, 32'd1);
        tick(1);
        check_reg0("ill_fn_r3", 5'd3, 32'd12);
        check("ill_fn_pc", pc0, 32'h80);

        // reset asserted mid-MEM of lw
        tick(3);
        check("rmem_state", {29'd0, state0}, 32'd3);
        ready = 1'b0;
        tick(1);
        #2;
        reset = 1'b1;
        #1;
        check("rmem_req", {31'd0, bus0.mem_req}, 32'd0);
        check("rmem_state_rst", {29'd0, state0}, 32'd0);
        check("rmem_pc", pc0, 32'h0);
        check("rmem_ir", inst0, 32'h0);
        check_reg0("rmem_r16", 5'd16, 32'h0);
        ready = 1'b1;
        tick(1);
        reset = 1'b0;
        #1;
        check("post_rst_req", {31'd0, bus0.mem_req}, 32'd1);
        check("post_rst_addr", bus0.mem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter OVF_TRAP, default 1, when 1 a signed overflow on add/sub/addi suppresses the register write.
REQ-003 cpu_clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 mem_req  out  1  memory access request, held until accepted.
REQ-006 mem_we  out  1  1 means write, valid while mem_req=1.
REQ-007 mem_addr  out  32  byte address, valid while mem_req=1.
REQ-008 mem_wdata  out  32  store data, valid while mem_req=1 and mem_we=1.
REQ-009 mem_rdata  in  32  read data, sampled on the edge where mem_ready=1.
REQ-010 mem_ready  in  1  access completes on any rising edge with mem_req=1 and mem_ready=1.
REQ-011 reg_num  in  5  test read address, combinational.
REQ-012 reg_data  out  32  register[reg_num], combinational.
REQ-013 PC_Current  out  32  current PC register.
REQ-014 inst  out  32  instruction register (IR).
REQ-015 state  out  3  FSM state code: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-016 overflow  out  1  one-cycle pulse in EXEC on signed overflow of add/sub/addi.
REQ-017 illegal  out  1  one-cycle pulse in EXEC for an unsupported opcode or funct.

Function
REQ-018 Supported instructions: R-type (op 000000) add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010, jr 001000; addi 001000, andi 001100, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_addr=PC_Current; on an accepting edge IR<=mem_rdata, PC<=PC+4, next DECODE; otherwise remain in FETCH with outputs stable.
REQ-020 DECODE: latch A<=reg[rs], B<=reg[rt], next EXEC.
REQ-021 EXEC routing by instruction class:
- ALU ops: ALUOut<=result, next WB.
- lw/sw: ALUOut<=A+signext(imm), next MEM.
- beq/bne: if taken, PC<=PC+(signext(imm)<<2); next FETCH.
- j: PC<={PC[31:28],imm26,2'b00}; next FETCH.
- jal: same target as j, reg[31]<=PC; next FETCH.
- jr: PC<=A; next FETCH.
- illegal: no architectural change; next FETCH.
REQ-022 Immediate extension: addi, lw, sw, beq, bne sign-extend; andi, ori zero-extend; sll/srl shift B by inst[10:6].
REQ-023 slt is a signed compare producing 32'd1 or 32'd0.
REQ-024 MEM: mem_req=1, mem_addr=ALUOut.
- sw: mem_we=1, mem_wdata=B; on accept, next FETCH.
- lw: mem_we=0; on accept, MDR<=mem_rdata, next WB.
- Without mem_ready, remain in MEM with outputs stable.
REQ-025 WB: destination is rd for R-type, rt otherwise; data is MDR for lw, ALUOut otherwise; next FETCH.
REQ-026 Writes to register 0 are discarded; register 0 always reads 0.
REQ-027 With OVF_TRAP=1 and overflow, WB performs no write; with OVF_TRAP=0 the wrapped result is written.
REQ-028 mem_req=0 in DECODE, EXEC and WB; mem_we=0 whenever mem_req=0.
REQ-029 Latency with mem_ready tied 1: R-type/I-type ALU 4 cycles, lw 5, sw 4, branch/jump 3; each wait cycle adds 1.
REQ-030 jr with rs=31 immediately after jal uses the newly written reg[31].
REQ-031 PC wraps modulo 2^32.

Reset
REQ-032 While reset=1 (asynchronous): state=FETCH, PC=RESET_PC, IR=0, A=B=ALUOut=MDR=0, all 32 registers=0, overflow=illegal=0.
REQ-033 mem_req follows FETCH after reset deassertion; an access pending when reset is asserted is abandoned, with no IR, MDR or register update.

Verification
REQ-034 Reset, then mem_ready=1 and memory holding addi $1,$0,5 ; addi $2,$0,7 ; add $3,$1,$2 -> reg[3]=12 after 12 cycles; PC_Current=12.
REQ-035 sw $3,4($0) then lw $4,4($0) with mem_ready low for 3 cycles in each MEM and FETCH -> store sees addr=4 and wdata=12; reg[4]=12; each instruction takes 3 extra cycles per stalled access.
REQ-036 beq $1,$1,+2 at PC=0x20 -> next fetch address 0x2C; bne $1,$1,+2 -> next fetch address 0x24.
REQ-037 jal to 0x100 at PC=0x40 then jr $31 -> reg[31]=0x44; fetch sequence 0x100 then 0x44.
REQ-038 addi $5,$0,0x7FFF then add of 0x7FFFFFFF+1 with OVF_TRAP=1 -> overflow pulses and the destination is unchanged; with OVF_TRAP=0 the destination is 0x80000000.
REQ-039 Opcode 111111 -> illegal pulses once, no state change; reset asserted mid-MEM -> mem_req drops within the same cycle and PC=RESET_PC.
